// File: rtl/uart_led_channels.sv
// Multi-channel LED driver: off / on / blink / pulse-stretched activity per channel.
// Optional UART_LED_PHASE_SYNC_EN: any accepted write restarts all blinking channels in phase.
module uart_led_channels #(
  parameter int CHANNELS   = 4,
  parameter int CNT_BITS   = 24,
  parameter int UART_CLOCK = 115200,
  parameter int STRETCH    = 11520,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                uart_clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_BITS-1:0]  cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_BITS-1:0] cfg_half,
  input  logic [CHANNELS-1:0] activity,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] toggle
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_ACT   = 2'b11
  } mode_t;

  mode_t               mode_q [CHANNELS];
  logic [CNT_BITS-1:0] half_q [CHANNELS];
  logic [CNT_BITS-1:0] cnt_q  [CHANNELS];
  logic [CNT_BITS-1:0] str_q  [CHANNELS];
  logic [CHANNELS-1:0] tc;
  logic                wr_ok;

  assign wr_ok = cfg_we && (32'(cfg_chan) < 32'(CHANNELS));

  // half of zero behaves as one, so the terminal count is then counter == 0
  always_comb begin
    tc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tc[i] = (half_q[i] == '0) ? (cnt_q[i] == '0)
                                : (cnt_q[i] == half_q[i] - CNT_BITS'(1));
    end
  end

  always_ff @(posedge uart_clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        mode_q[i] <= MODE_OFF;
        half_q[i] <= CNT_BITS'(UART_CLOCK);
        cnt_q[i]  <= '0;
        str_q[i]  <= '0;
        led[i]    <= 1'b0;
        toggle[i] <= 1'b0;
      end else if (wr_ok && (32'(cfg_chan) == 32'(i))) begin
        mode_q[i] <= mode_t'(cfg_mode);
        half_q[i] <= cfg_half;
        cnt_q[i]  <= '0;
        str_q[i]  <= '0;
        led[i]    <= (cfg_mode == MODE_ON);
        toggle[i] <= 1'b0;
      end
`ifdef UART_LED_PHASE_SYNC_EN
      else if (wr_ok && (mode_q[i] == MODE_BLINK)) begin
        cnt_q[i]  <= '0;
        led[i]    <= 1'b0;
        toggle[i] <= 1'b0;
      end
`endif
      else begin
        case (mode_q[i])
          MODE_OFF: begin
            cnt_q[i]  <= '0;
            str_q[i]  <= '0;
            led[i]    <= 1'b0;
            toggle[i] <= 1'b0;
          end
          MODE_ON: begin
            cnt_q[i]  <= '0;
            str_q[i]  <= '0;
            led[i]    <= 1'b1;
            toggle[i] <= 1'b0;
          end
          MODE_BLINK: begin
            str_q[i]  <= '0;
            toggle[i] <= tc[i];
            if (tc[i]) begin
              cnt_q[i] <= '0;
              led[i]   <= ~led[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
            end
          end
          default: begin
            cnt_q[i]  <= '0;
            toggle[i] <= 1'b0;
            if (activity[i]) begin
              str_q[i] <= CNT_BITS'(STRETCH);
              led[i]   <= 1'b1;
            end else if (str_q[i] != '0) begin
              str_q[i] <= str_q[i] - CNT_BITS'(1);
              if (str_q[i] == CNT_BITS'(1)) led[i] <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_led_channels.sv
// Directed bench for uart_led_channels with three channels and a short stretch.
// Expected phase-sync behaviour follows UART_LED_PHASE_SYNC_EN.
module tb_uart_led_channels;

  localparam int CHANNELS = 3;
  localparam int CNT_BITS = 8;

  logic                uart_clock = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [1:0]          cfg_chan;
  logic [1:0]          cfg_mode;
  logic [CNT_BITS-1:0] cfg_half;
  logic [CHANNELS-1:0] activity;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] toggle;

  int checks = 0;
  int errors = 0;

  uart_led_channels #(
    .CHANNELS(CHANNELS), .CNT_BITS(CNT_BITS), .UART_CLOCK(100), .STRETCH(5)
  ) dut (
    .uart_clock(uart_clock), .reset(reset), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .activity(activity),
    .led(led), .toggle(toggle)
  );

  always #5 uart_clock = ~uart_clock;

  task automatic tick();
    @(posedge uart_clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] md, input logic [CNT_BITS-1:0] hf);
    cfg_we = 1'b1; cfg_chan = ch; cfg_mode = md; cfg_half = hf;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; activity = 3'b111;
    cfg_we = 1'b1; cfg_chan = 2'd0; cfg_mode = 2'b01; cfg_half = 8'd3;
    tick();
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL reset_override led=%b toggle=%b exp 000/000", led, toggle);
    end
    reset = 1'b0; cfg_we = 1'b0; activity = 3'b000;
    tick();
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL reset_idle led=%b toggle=%b exp 000/000", led, toggle);
    end
  endtask

  task automatic test_blink();
    logic [8:0] led_e;
    logic [8:0] tog_e;
    led_e = 9'b100011100;
    tog_e = 9'b100100100;
    do_reset();
    wr(2'd0, 2'b10, 8'd3);
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL blink_write led=%b toggle=%b exp 000/000", led, toggle);
    end
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (led !== {2'b00, led_e[j-1]} || toggle !== {2'b00, tog_e[j-1]}) begin
        errors++;
        $display("FAIL blink_h3 cyc%0d led=%b toggle=%b exp %b/%b", j, led, toggle,
                 {2'b00, led_e[j-1]}, {2'b00, tog_e[j-1]});
      end
    end
  endtask

  task automatic test_activity();
    do_reset();
    wr(2'd1, 2'b11, 8'd0);
    activity = 3'b011;
    tick();
    activity = 3'b000;
    checks++;
    if (led !== 3'b010 || toggle !== 3'b000) begin
      errors++; $display("FAIL act_strobe led=%b toggle=%b exp 010/000", led, toggle);
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++;
      if (led !== ((j < 5) ? 3'b010 : 3'b000) || toggle !== 3'b000) begin
        errors++; $display("FAIL act_stretch cyc%0d led=%b toggle=%b exp %b/000", j, led, toggle,
                           (j < 5) ? 3'b010 : 3'b000);
      end
    end
    activity = 3'b010; tick(); activity = 3'b000;
    tick(); tick();
    activity = 3'b010; tick(); activity = 3'b000;
    for (int j = 1; j <= 5; j++) begin
      tick();
      checks++;
      if (led !== ((j < 5) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL act_retrigger cyc%0d led=%b exp %b", j, led,
                           (j < 5) ? 3'b010 : 3'b000);
      end
    end
  endtask

  task automatic test_half_zero();
    do_reset();
    wr(2'd2, 2'b10, 8'd0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++;
      if (led !== ((j % 2 == 1) ? 3'b100 : 3'b000) || toggle !== 3'b100) begin
        errors++; $display("FAIL half0 cyc%0d led=%b toggle=%b exp %b/100", j, led, toggle,
                           (j % 2 == 1) ? 3'b100 : 3'b000);
      end
    end
    wr(2'd2, 2'b01, 8'd0);
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) tick();
      checks++;
      if (led !== 3'b100 || toggle !== 3'b000) begin
        errors++; $display("FAIL mode_on cyc%0d led=%b toggle=%b exp 100/000", j, led, toggle);
      end
    end
  endtask

  task automatic test_range_and_abort();
    do_reset();
    wr(2'd3, 2'b01, 8'd1);
    tick();
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL out_of_range led=%b toggle=%b exp 000/000", led, toggle);
    end
    wr(2'd0, 2'b10, 8'd1);
    wr(2'd1, 2'b11, 8'd0);
    activity = 3'b010; tick(); activity = 3'b000;
    tick();
    reset = 1'b1; activity = 3'b010;
    tick();
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL reset_abort led=%b toggle=%b exp 000/000", led, toggle);
    end
    reset = 1'b0;
    tick(); tick();
    activity = 3'b000;
    checks++;
    if (led !== 3'b000 || toggle !== 3'b000) begin
      errors++; $display("FAIL after_abort led=%b toggle=%b exp 000/000", led, toggle);
    end
  endtask

  task automatic test_collision();
    do_reset();
    wr(2'd0, 2'b10, 8'd3);
    tick(); tick();
    wr(2'd0, 2'b10, 8'd3);
    checks++;
    if (led[0] !== 1'b0 || toggle[0] !== 1'b0) begin
      errors++; $display("FAIL wr_vs_tc led0=%b toggle0=%b exp 0/0", led[0], toggle[0]);
    end
    for (int j = 1; j <= 3; j++) begin
      tick();
      checks++;
      if (led[0] !== (j == 3) || toggle[0] !== (j == 3)) begin
        errors++; $display("FAIL wr_restart cyc%0d led0=%b toggle0=%b exp %b/%b", j,
                           led[0], toggle[0], (j == 3), (j == 3));
      end
    end
    wr(2'd1, 2'b11, 8'd0);
    activity = 3'b010; tick(); activity = 3'b000;
    checks++;
    if (led[1] !== 1'b1) begin
      errors++; $display("FAIL act_lit led1=%b exp 1", led[1]);
    end
    activity = 3'b010;
    wr(2'd1, 2'b11, 8'd0);
    activity = 3'b000;
    checks++;
    if (led[1] !== 1'b0 || toggle[1] !== 1'b0) begin
      errors++; $display("FAIL wr_vs_act led1=%b toggle1=%b exp 0/0", led[1], toggle[1]);
    end
    tick();
    checks++;
    if (led[1] !== 1'b0) begin
      errors++; $display("FAIL act_dropped led1=%b exp 0", led[1]);
    end
  endtask

  task automatic test_phase();
    logic [2:0] led_e [4];
    logic [2:0] tog_e [4];
    logic [2:0] led_w;
    logic [2:0] led_f;
`ifdef UART_LED_PHASE_SYNC_EN
    led_w = 3'b000;
    led_e = '{3'b000, 3'b000, 3'b000, 3'b011};
    tog_e = '{3'b000, 3'b000, 3'b000, 3'b011};
    led_f = 3'b100;
`else
    led_w = 3'b010;
    led_e = '{3'b010, 3'b010, 3'b000, 3'b001};
    tog_e = '{3'b000, 3'b000, 3'b010, 3'b001};
    led_f = 3'b101;
`endif
    do_reset();
    wr(2'd0, 2'b10, 8'd3);
    wr(2'd1, 2'b10, 8'd4);
    tick(); tick(); tick(); tick();
    checks++;
    if (led !== 3'b011 || toggle !== 3'b010) begin
      errors++; $display("FAIL phase_offset led=%b toggle=%b exp 011/010", led, toggle);
    end
    wr(2'd0, 2'b10, 8'd4);
    checks++;
    if (led !== led_w || toggle !== 3'b000) begin
      errors++; $display("FAIL phase_write led=%b toggle=%b exp %b/000", led, toggle, led_w);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++;
      if (led !== led_e[j] || toggle !== tog_e[j]) begin
        errors++; $display("FAIL phase_run cyc%0d led=%b toggle=%b exp %b/%b", j + 1,
                           led, toggle, led_e[j], tog_e[j]);
      end
    end
    wr(2'd2, 2'b01, 8'd0);
    checks++;
    if (led !== led_f || toggle !== 3'b000) begin
      errors++; $display("FAIL phase_other_write led=%b toggle=%b exp %b/000", led, toggle, led_f);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_chan = '0; cfg_mode = '0; cfg_half = '0; activity = '0;
    test_reset();
    test_blink();
    test_activity();
    test_half_zero();
    test_range_and_abort();
    test_collision();
    test_phase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_led_channels.md
Name: uart_led_channels

Overview:
- Multi-channel, run-time configurable LED driver. Parametrised successor to the single fixed-rate board blinker.
- Each channel runs in one of four modes: off, on, free-running blink with programmable half-period, or activity indicator (pulse-stretched).
- Sits on the uart_clock domain beside the UART core. Drives board LEDs from UART status/activity strobes and from host configuration writes.

Parameters:
- CHANNELS, 4: number of independent LED channels (1..32).
- CNT_BITS, 24: width of the per-channel half-period counter and cfg_half.
- UART_CLOCK, 115200: reset value of every channel's half-period, in uart_clock cycles.
- STRETCH, 11520: activity stretch length, in cycles (100 ms at 115200 Hz). Must be ≥1 and < 2^CNT_BITS.

Ports:
- uart_clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_chan  in  CH_BITS  target channel; CH_BITS = max(1, $clog2(CHANNELS)).
- cfg_mode  in  2  00 off, 01 on, 10 blink, 11 activity.
- cfg_half  in  CNT_BITS  blink half-period in cycles; 0 is treated as 1.
- activity  in  CHANNELS  per-channel event strobe, sampled every cycle.
- led  out  CHANNELS  registered LED drive, 1 = lit.
- toggle  out  CHANNELS  registered one-cycle pulse, coincident with each blink-mode edge on led.

Behaviour:
- Clock and reset: one clock, uart_clock. Reset is synchronous and active-high.
- Reset (sampled high at a clock edge), for every channel:
  - mode=00, half=UART_CLOCK, counter=0, stretch=0, led=0, toggle=0.
  - Overrides cfg_we and activity in the same cycle.
  - Mid-blink or mid-stretch reset aborts at once; no residual pulse follows.
- Per-channel state: mode (2b), half (CNT_BITS), counter (CNT_BITS), stretch (CNT_BITS).
- Mode 00 (off): led=0, counter and stretch held at 0.
- Mode 01 (on): led=1, counter and stretch held at 0.
- Mode 10 (blink):
  - counter increments each cycle.
  - When counter == eff_half-1 (eff_half = max(half,1)): counter←0, led←~led, toggle←1. Otherwise toggle←0.
  - led therefore changes exactly every eff_half cycles.
  - Period is 2*eff_half cycles, 50% duty. half=1 toggles every cycle.
- Mode 11 (activity):
  - activity[i]=1 at edge k: stretch←STRETCH, led←1 from edge k.
  - Otherwise, if stretch>0: stretch←stretch-1, and led←0 on the edge where stretch reaches 0.
  - Net effect: led stays high for exactly STRETCH cycles after the last strobe.
  - Retrigger while lit reloads stretch (extends, no glitch). A continuous strobe keeps led at 1.
  - toggle stays 0 in this mode.
- Config write (cfg_we=1, cfg_chan<CHANNELS):
  - At the edge: mode←cfg_mode, half←cfg_half, counter←0, stretch←0, toggle←0.
  - led←1 if new mode is 01, else led←0.
  - Latency: the new mode is visible on led one cycle after the write edge.
  - Blink restarts from the low phase; the first toggle comes eff_half cycles after the write edge.
- cfg_chan ≥ CHANNELS: write ignored, no state changes.
- Same-cycle events on one channel:
  - Write beats a blink terminal count and beats activity; that cycle's activity strobe is dropped.
  - activity to a channel not in mode 11 is ignored.
- Channel independence: channels other than cfg_chan are unaffected by a write (except under the optional feature).
- Width rule: counter compare is unsigned, full CNT_BITS. half may change only through a write, which also clears counter, so counter never passes eff_half-1.

Optional Feature:
- Macro: UART_LED_PHASE_SYNC_EN.
- Defined: any accepted config write also clears counter and toggle on every channel in mode 10. Each such channel also sets led←0, so all blinking channels restart in phase. Channels in modes 00/01/11 are unaffected.
- Undefined: a write touches only the addressed channel, as above.

Test Plan:
- Reset, then write ch0 mode 10, half 3 -> led[0] is 0,0,0,1,1,1,0,…; toggle[0] pulses on each edge; other leds stay 0.
- Write ch1 mode 11; strobe activity[1] once; STRETCH=5 -> led[1]=1 for exactly 5 cycles. A second strobe at cycle 3 keeps it lit until 5 cycles after that strobe.
- Write ch2 half 0 mode 10 -> led[2] toggles every cycle. Write ch2 mode 01 -> led[2]=1 next cycle and stays 1; toggle[2]=0.
- Write cfg_chan=CHANNELS (out of range) with mode 01 -> no led change. Assert reset mid-blink and mid-stretch -> all led/toggle are 0 the next cycle; mode off.
- Write ch0 in the same cycle as its terminal count, and activity on an activity-mode channel in the same cycle as a write to it -> write wins in both cases: counter cleared, led low, no toggle pulse.
- With UART_LED_PHASE_SYNC_EN: ch0 and ch1 blinking (half 4) at offset phase, write ch3 mode 01 -> ch0 and ch1 led both 0 next cycle and toggle together from then on.
